axi_frame_tagger: RTL and testbench

- Sits directly downstream of the channelizer input FIFO.
- Consumes its continuous sample stream and tags frame boundaries with tlast every frame_len accepted samples, so the polyphase/FFT stage sees aligned blocks.
- Registered, fully back-pressurable AXI-Stream stage with a 2-entry skid buffer; s_axis_tready is driven from a register.
- Frame length is runtime-programmable and takes effect only on frame boundaries.

---
 rtl/axi_frame_tagger_if.sv | 20 ++
 rtl/axi_frame_tagger.sv | 144 ++++++++++++++
 tb/tb_axi_frame_tagger.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_frame_tagger_if.sv
// AXI-Stream bundle used on both sides of axi_frame_tagger.
// tuser exists only when AXI_FRAME_TAGGER_FRAME_CNT_EN is defined.
interface axi_frame_tagger_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
    logic [CNT_WIDTH-1:0]  tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
`else
    modport master (output tvalid, output tdata, output tlast, input tready);
`endif
    // The input side carries a raw sample stream, so tlast/tuser are not consumed.
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axi_frame_tagger.sv
// Frame tagger: marks tlast every active_len accepted samples behind a registered
// output stage with a 2-entry skid buffer. Frame index on tuser with AXI_FRAME_TAGGER_FRAME_CNT_EN.
module axi_frame_tagger #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic [LEN_WIDTH-1:0] frame_len,
    axi_frame_tagger_if.slave    s_axis,
    axi_frame_tagger_if.master   m_axis
);
    localparam int LW1 = LEN_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
        logic [CNT_WIDTH-1:0]  idx;
`endif
    } entry_t;

    entry_t               out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    entry_t               skid_q [2];
    entry_t               skid_d [2];
    logic [1:0]           occ_q, occ_d;
    logic                 s_ready_q, s_ready_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
    logic [CNT_WIDTH-1:0] fidx_q, fidx_d;
`endif

    logic                 accept;
    logic                 out_load;
    logic                 tag_last;
    logic                 pop;
    logic                 push;
    logic [1:0]           wr_pos;
    logic [LW1-1:0]       len_ext;
    entry_t               in_ent;

    always_comb begin
        accept   = s_axis.tvalid & s_ready_q;
        // Length 0 stands for 2^LEN_WIDTH, hence the one-bit-wider compare.
        len_ext  = (len_q == '0) ? (LW1'(1) << LEN_WIDTH) : {1'b0, len_q};
        tag_last = ({1'b0, cnt_q} == (len_ext - LW1'(1)));

        in_ent.data = s_axis.tdata;
        in_ent.last = tag_last;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
        in_ent.idx  = fidx_q;
        fidx_d      = fidx_q;
`endif
        cnt_d = cnt_q;
        len_d = len_q;
        if (accept) begin
            if (tag_last) begin
                cnt_d = '0;
                len_d = frame_len;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
                fidx_d = fidx_q + CNT_WIDTH'(1);
`endif
            end else begin
                cnt_d = cnt_q + LEN_WIDTH'(1);
            end
        end

        out_load = ~out_valid_q | m_axis.tready;
        pop      = out_load & (occ_q != 2'd0);
        push     = accept & ~(out_load & (occ_q == 2'd0));

        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_load) begin
            if (pop) begin
                out_d       = skid_q[0];
                out_valid_d = 1'b1;
            end else if (accept) begin
                out_d       = in_ent;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        skid_d[0] = skid_q[0];
        skid_d[1] = skid_q[1];
        if (pop) begin
            skid_d[0] = skid_q[1];
        end
        // Tail slot is computed after the pop so a same-cycle pop+push keeps FIFO order.
        wr_pos = occ_q - {1'b0, pop};
        if (push) begin
            if (wr_pos == 2'd0) begin
                skid_d[0] = in_ent;
            end else begin
                skid_d[1] = in_ent;
            end
        end

        occ_d     = occ_q - {1'b0, pop} + {1'b0, push};
        s_ready_d = (occ_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            occ_q       <= 2'd0;
            s_ready_q   <= 1'b0;
            cnt_q       <= '0;
            len_q       <= frame_len;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
            fidx_q      <= '0;
`endif
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q[0]   <= skid_d[0];
            skid_q[1]   <= skid_d[1];
            occ_q       <= occ_d;
            s_ready_q   <= s_ready_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
            fidx_q      <= fidx_d;
`endif
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tlast  = out_q.last;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
    assign m_axis.tuser  = out_q.idx;
`endif

endmodule

// File: tb/tb_axi_frame_tagger.sv
// Bench for axi_frame_tagger: frame-rule model with an output queue, per-cycle compare,
// plus literal tlast/tuser sequences per scenario.
module tb_axi_frame_tagger;
    localparam int DW = 32;
    localparam int LW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [LW-1:0] frame_len;

    always #5 clk = ~clk;

    axi_frame_tagger_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) s_if ();
    axi_frame_tagger_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) m_if ();

    assign s_if.tlast = 1'b0;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
    assign s_if.tuser = '0;
`endif

    axi_frame_tagger #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .frame_len  (frame_len),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rmode  = 0;   // 0: tready high, 1: toggle each cycle, 2: tready low

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            user;
    } exp_t;

    exp_t exp_q[$];
    int   m_pos, m_len, m_fidx;
    int   last_log[$];
    int   user_log[$];
    int   first_acc, first_xfer, last_xfer, n_xfer;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            prev_user;

    always @(posedge clk) cyc++;

    function automatic int decode_len(input logic [LW-1:0] v);
        return (v == '0) ? (1 << LW) : int'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int want[$]);
        chk({name, "_count"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk(name, 64'(got[i]), 64'(want[i]));
    endtask

    // m_axis.tready pattern
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Model update and output compare, sampled mid-low-phase.
    initial begin
        exp_t e;
        int   user_val;
        forever begin
            @(negedge clk);
            #2;
            if (sync_reset) begin
                exp_q.delete();
                m_pos      = 0;
                m_len      = decode_len(frame_len);
                m_fidx     = 0;
                prev_stall = 1'b0;
            end else begin
                user_val = 0;
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
                user_val = int'(m_if.tuser);
`endif
                if (prev_stall) begin
                    checks++;
                    if (!(m_if.tvalid && m_if.tdata == prev_data && m_if.tlast == prev_last
                          && user_val == prev_user)) begin
                        errors++;
                        $display("FAIL hold: got v=%0b d=%0d l=%0b, expected v=1 d=%0d l=%0b",
                                 m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
                    end
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: got d=%0d, expected no transfer", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (m_if.tdata !== e.data || m_if.tlast !== e.last
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
                            || user_val != e.user
`endif
                           ) begin
                            errors++;
                            $display("FAIL output: got d=%0d l=%0b u=%0d, expected d=%0d l=%0b u=%0d",
                                     m_if.tdata, m_if.tlast, user_val, e.data, e.last, e.user);
                        end
                    end
                    if (m_if.tlast) last_log.push_back(int'(m_if.tdata));
                    user_log.push_back(user_val);
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                    n_xfer++;
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                prev_last  = m_if.tlast;
                prev_user  = user_val;

                if (s_if.tvalid && s_if.tready) begin
                    e.data = s_if.tdata;
                    e.last = ((m_pos + 1) == m_len);
                    e.user = m_fidx;
                    if (e.last) begin
                        m_pos  = 0;
                        m_len  = decode_len(frame_len);
                        m_fidx = (m_fidx + 1) % (1 << CW);
                    end else begin
                        m_pos++;
                    end
                    exp_q.push_back(e);
                    if (first_acc < 0) first_acc = cyc;
                    checks++;
                    if (exp_q.size() > 3) begin
                        errors++;
                        $display("FAIL occupancy: got %0d samples held, expected at most 3", exp_q.size());
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        last_log.delete();
        user_log.delete();
        first_acc  = -1;
        first_xfer = -1;
        last_xfer  = -1;
        n_xfer     = 0;
    endtask

    task automatic do_reset(input logic [LW-1:0] fl);
        @(negedge clk);
        frame_len   = fl;
        sync_reset  = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
        chk("rst_m_tuser",  64'(m_if.tuser),  64'd0);
`endif
        @(negedge clk);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", 64'(s_if.tready), 64'd1);
    endtask

    // Present n samples base..base+n-1; frame_len switches to chg_val while sample chg_at is offered.
    task automatic send(input int n, input int base, input int chg_at, input logic [LW-1:0] chg_val);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = DW'(base + i);
            if (i == chg_at) frame_len = chg_val;
            w = 0;
            while (!s_if.tready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept of sample %0d within 100 cycles, expected accept", base + i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        rmode = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    int pin[$];

    initial begin
        sync_reset  = 1'b1;
        frame_len   = 3'd4;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        clear_logs();
        repeat (3) @(posedge clk);

        // Streaming, frame_len=4
        rmode = 0;
        do_reset(3'd4);
        clear_logs();
        send(12, 0, -1, 3'd0);
        drain();
        pin = '{3, 7, 11};
        chk_list("stream_tlast", last_log, pin);
        chk("stream_latency", 64'(first_xfer - first_acc), 64'd1);
        chk("stream_no_bubble", 64'(last_xfer - first_xfer), 64'd11);
        chk("stream_count", 64'(n_xfer), 64'd12);

        // Backpressure, frame_len=0 encodes 8
        rmode = 1;
        do_reset(3'd0);
        rmode = 1;
        clear_logs();
        send(32, 100, -1, 3'd0);
        drain();
        pin = '{107, 115, 123, 131};
        chk_list("bp_tlast", last_log, pin);
        chk("bp_count", 64'(n_xfer), 64'd32);

        // Length change 4 -> 6 mid-frame
        rmode = 0;
        do_reset(3'd4);
        clear_logs();
        send(16, 200, 2, 3'd6);
        drain();
        pin = '{203, 209, 215};
        chk_list("lenchg_tlast", last_log, pin);

        // frame_len=1 under backpressure
        rmode = 1;
        do_reset(3'd1);
        rmode = 1;
        clear_logs();
        send(6, 300, -1, 3'd0);
        drain();
        pin = '{300, 301, 302, 303, 304, 305};
        chk_list("len1_tlast", last_log, pin);

        // frame_len changes 2 -> 3 on the boundary sample itself
        rmode = 0;
        do_reset(3'd2);
        clear_logs();
        send(8, 400, 1, 3'd3);
        drain();
        pin = '{401, 404, 407};
        chk_list("bndchg_tlast", last_log, pin);

        // Reset mid-frame with samples buffered
        rmode = 0;
        do_reset(3'd4);
        clear_logs();
        send(5, 500, -1, 3'd0);
        rmode = 2;
        send(2, 505, -1, 3'd0);
        do_reset(3'd4);
        rmode = 0;
        send(4, 600, -1, 3'd0);
        drain();
        pin = '{503, 603};
        chk_list("midrst_tlast", last_log, pin);

`ifdef AXI_FRAME_TAGGER_FRAME_CNT_EN
        // Frame index wraps modulo 4
        rmode = 0;
        do_reset(3'd2);
        clear_logs();
        send(10, 700, -1, 3'd0);
        drain();
        pin = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        chk_list("tuser_seq", user_log, pin);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
